// File: rtl/toggle_pkg.sv
// Shared constants for the toggle-signalling sender/receiver pair.
// Default sizes and widths of the optional statistics counters.
package toggle_pkg;

   localparam int TGL_SYNC_STAGES  = 2;
   localparam int TGL_CNT_W        = 4;
   localparam int TGL_EVT_TOTAL_W  = 16;
   localparam int TGL_DROP_TOTAL_W = 8;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a level line crossing into the clk domain.
// Shared by the toggle receiver (t_in) and the future sender (ack_t).
module toggle_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Receiver for toggle-encoded events: synchronise, detect flips, queue, hand off via valid/ready.
// Defining TOGGLE_EVENT_RX_STATS_EN adds evt_total and drop_total statistics outputs.
module toggle_event_receiver
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES = TGL_SYNC_STAGES,
   parameter int CNT_W       = TGL_CNT_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        t_in,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [CNT_W-1:0]            pending,
   output logic                        ack_t,
   output logic                        overflow,
   input  logic                        clr_ovf
`ifdef TOGGLE_EVENT_RX_STATS_EN
   ,
   output logic [TGL_EVT_TOTAL_W-1:0]  evt_total,
   output logic [TGL_DROP_TOTAL_W-1:0] drop_total
`endif
);

   logic             t_s;
   logic             t_prev;
   logic             toggle_edge;
   logic             take;
   logic             full;
   logic             drop;
   logic [CNT_W-1:0] next_pending;

   toggle_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (t_in),
      .q     (t_s)
   );

   assign toggle_edge = t_s ^ t_prev;
   assign evt_valid   = (pending != '0);
   assign take        = evt_valid & evt_ready;
   assign full        = (pending == {CNT_W{1'b1}});
   assign drop        = toggle_edge & ~take & full;

   // An arrival and a take in the same cycle cancel, so a full counter never drops in that case.
   always_comb begin
      next_pending = pending;
      if (toggle_edge && !take && !full) begin
         next_pending = pending + 1'b1;
      end else if (take && !toggle_edge) begin
         next_pending = pending - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_prev   <= 1'b0;
         pending  <= '0;
         ack_t    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         t_prev   <= t_s;
         pending  <= next_pending;
         ack_t    <= ack_t ^ take;
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef TOGGLE_EVENT_RX_STATS_EN
   // evt_total counts every detected flip, dropped or not, and wraps; drop_total saturates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evt_total  <= '0;
         drop_total <= '0;
      end else begin
         if (toggle_edge) begin
            evt_total <= evt_total + 1'b1;
         end
         if (drop && (drop_total != {TGL_DROP_TOTAL_W{1'b1}})) begin
            drop_total <= drop_total + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Self-checking bench for toggle_event_receiver at default parameters (SYNC_STAGES=2, CNT_W=4).
// Table-driven vectors plus hand-written saturation, simultaneous, drain and async-reset sequences.
module tb_toggle_event_receiver;

   typedef struct {
      logic       t;
      logic       rdy;
      logic       clr;
      logic [3:0] pend;
      logic       valid;
      logic       ack;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [3:0] pend;
      logic       valid;
      logic       ack;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       t_in;
   logic       evt_valid;
   logic       evt_ready;
   logic [3:0] pending;
   logic       ack_t;
   logic       overflow;
   logic       clr_ovf;
`ifdef TOGGLE_EVENT_RX_STATS_EN
   logic [15:0] evt_total;
   logic [7:0]  drop_total;
`endif

   int   tests;
   int   failures;
   int   flips;
   exp_t sb[$];
   vec_t vecs[26];

   toggle_event_receiver dut (
      .clk       (clk),
      .reset     (reset),
      .t_in      (t_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .pending   (pending),
      .ack_t     (ack_t),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
`ifdef TOGGLE_EVENT_RX_STATS_EN
      ,
      .evt_total  (evt_total),
      .drop_total (drop_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input int p, input logic a, input logic o);
      exp_t e;
      e.pend  = p[3:0];
      e.valid = (p != 0);
      e.ack   = a;
      e.ovf   = o;
      return e;
   endfunction

   task automatic applyStimulus(input logic t, input logic rdy, input logic clr, input exp_t e);
      @(negedge clk);
      if (t !== t_in) flips++;
      t_in      = t;
      evt_ready = rdy;
      clr_ovf   = clr;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL %s: no expected entry queued", name);
         return;
      end
      e = sb.pop_front();
      if (pending !== e.pend || evt_valid !== e.valid || ack_t !== e.ack || overflow !== e.ovf) begin
         failures++;
         $display("[TB] FAIL %s: got pending=%0d valid=%b ack_t=%b overflow=%b, expected pending=%0d valid=%b ack_t=%b overflow=%b",
                  name, pending, evt_valid, ack_t, overflow, e.pend, e.valid, e.ack, e.ovf);
      end
   endtask

   task automatic step(input logic t, input logic rdy, input logic clr, input exp_t e, input string name);
      applyStimulus(t, rdy, clr, e);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

   task automatic checkValue(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic cur_t;
      logic cur_ack;
      int   p;

      tests     = 0;
      failures  = 0;
      flips     = 0;
      reset     = 1'b0;
      t_in      = 1'b0;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      sb.push_back(mk(0, 1'b0, 1'b0));
      checkOutput("reset_state");
      @(negedge clk);
      reset = 1'b1;

      // Basic events, consume, ready-without-valid, and edge+take with one pending.
      for (int i = 0; i < 26; i++) begin
         exp_t e;
         e.pend  = vecs[i].pend;
         e.valid = vecs[i].valid;
         e.ack   = vecs[i].ack;
         e.ovf   = vecs[i].ovf;
         step(vecs[i].t, vecs[i].rdy, vecs[i].clr, e, $sformatf("vec%0d", i));
      end

      // Saturation: 15 flips fill the counter, the 16th is dropped and sets overflow.
      cur_t = t_in;
      for (int f = 0; f < 16; f++) begin
         cur_t = ~cur_t;
         for (int s = 0; s < 4; s++) begin
            p = (s >= 2) ? ((f + 1 > 15) ? 15 : f + 1) : f;
            step(cur_t, 1'b0, 1'b0, mk(p, 1'b0, (f == 15 && s >= 2)), $sformatf("sat_f%0d_s%0d", f, s));
         end
      end
      step(cur_t, 1'b0, 1'b1, mk(15, 1'b0, 1'b0), "clr_ovf");

      // Full counter: arrival and take in the same cycle leave pending at 15 without overflow.
      cur_t = ~cur_t;
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b0, 1'b0), "sim_s0");
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b0, 1'b0), "sim_s1");
      step(cur_t, 1'b1, 1'b0, mk(15, 1'b1, 1'b0), "sim_edge_take");
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b1, 1'b0), "sim_s3");

      // Overflow set and clear in the same cycle: set wins.
      cur_t = ~cur_t;
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b1, 1'b0), "setwin_s0");
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b1, 1'b0), "setwin_s1");
      step(cur_t, 1'b0, 1'b1, mk(15, 1'b1, 1'b1), "setwin_drop_clr");
      step(cur_t, 1'b0, 1'b0, mk(15, 1'b1, 1'b1), "setwin_hold");
      step(cur_t, 1'b0, 1'b1, mk(15, 1'b1, 1'b0), "setwin_clear");

      // Continuous drain: one take per cycle, ack_t flips each time.
      cur_ack = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         cur_ack = ~cur_ack;
         step(cur_t, 1'b1, 1'b0, mk(15 - k, cur_ack, 1'b0), $sformatf("drain_%0d", k));
      end
      step(cur_t, 1'b1, 1'b0, mk(0, cur_ack, 1'b0), "drain_empty");

      // Queue four, consume one, then reset asynchronously mid-cycle.
      for (int f = 0; f < 4; f++) begin
         cur_t = ~cur_t;
         for (int s = 0; s < 4; s++) begin
            p = (s >= 2) ? f + 1 : f;
            step(cur_t, 1'b0, 1'b0, mk(p, cur_ack, 1'b0), $sformatf("queue_f%0d_s%0d", f, s));
         end
      end
      cur_ack = ~cur_ack;
      step(cur_t, 1'b1, 1'b0, mk(3, cur_ack, 1'b0), "pre_reset_take");
`ifdef TOGGLE_EVENT_RX_STATS_EN
      checkValue("evt_total", int'(evt_total), flips);
      checkValue("drop_total", int'(drop_total), 2);
`endif
      #2;
      reset = 1'b0;
      #1;
      sb.push_back(mk(0, 1'b0, 1'b0));
      checkOutput("async_reset");
`ifdef TOGGLE_EVENT_RX_STATS_EN
      checkValue("evt_total_reset", int'(evt_total), 0);
      checkValue("drop_total_reset", int'(drop_total), 0);
`endif
      t_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0), "post_reset_idle");
      checkValue("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
